shift_add_multiplier: RTL and testbench
=======================================

Name: shift_add_multiplier

Overview:
- Sequential unsigned shift-and-add multiplier; directly downstream of the serial-to-parallel input stages.
- Consumes the parallel operand words and their done flags from the X and Y shift-in stages.
- Computes the 2W-bit product in W iterations, then presents it with a done flag to the output/serializer stage.

Parameters:
W, 12, operand width in bits; product is 2W bits; iteration count is W.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
x_parallel  input  W  multiplicand from the X shift-in stage; sampled only at start.
fx  input  1  X operand valid (level) from the X shift-in stage.
y_parallel  input  W  multiplier from the Y shift-in stage; sampled only at start.
fy  input  1  Y operand valid (level) from the Y shift-in stage.
product  output  2W  registered product; held between operations.
busy  output  1  high while in MULT.
fp  output  1  product valid; high only in DONE.

Behaviour:
- Reset: reset is asynchronous, active-high; clock is clk. While reset is asserted:
  - state=IDLE, product=0, busy=0, fp=0.
  - accumulator, multiplier shift register and iteration counter = 0.
  - ready_q = 0.
- ready = fx & fy. ready_q is ready registered every clk.
- start = ready & ~ready_q, i.e. a rising edge of ready. After reset, ready already high counts as a rise.
- States: IDLE, MULT, DONE (2-bit encoding; unused code returns to IDLE).
- IDLE:
  - On an edge with start=1: mcand<=x_parallel, mplier<=y_parallel, acc<=0, count<=0, state<=MULT.
  - Otherwise hold.
  - product is not cleared on start.
- MULT, each edge:
  - sum = {1'b0,acc} + (mplier[0] ? mcand : 0), W+1 bits.
  - {acc, mplier} <= {sum, mplier} >> 1. The carry lands in acc MSB; no overflow is possible.
  - count <= count+1.
  - On the edge where count == W-1 (the Wth iteration): product <= shifted {acc, mplier}, state <= DONE.
- Latency:
  - Load edge E0; iterations on E1..EW.
  - fp=1 and product valid immediately after edge EW, i.e. W+1 edges after the first edge that sees start.
- DONE:
  - fp=1, busy=0.
  - Stays in DONE while ready=1.
  - On an edge with ready=0: state<=IDLE, fp<=0; product is held.
  - If ready is already 0 on entry, fp is high for exactly one cycle.
  - A new operation requires ready to fall and then rise again. A ready rise coinciding with the DONE->IDLE edge is not lost: start is evaluated in IDLE on the following edges via ready_q.
- In MULT, fx/fy/x_parallel/y_parallel are ignored. A ready drop or rise mid-operation does not abort or restart.
- Reset mid-operation: immediate return to reset values; no partial product is visible.
- Zero operands still take the full W iterations.
- Counter width: $clog2(W)+1 bits, so no wrap for any W.

Test Plan:
- Reset, then fx=fy=1 with x=3, y=5 -> busy high 12 cycles; fp rises 13 edges after the first edge that sees ready; product=15 (0x00000F).
- x=4095, y=4095 -> product=0xFFE001 (16769025); carry into acc MSB is exercised.
- x=0, y=2748 and x=2048, y=2 -> products 0 and 4096; each still takes 12 iterations.
- Hold fx=fy=1 after DONE -> fp stays 1, no restart. Drop fy -> fp=0 next edge, product held. Re-raise fy with x=7, y=9 -> product=63.
- Toggle fx low/high and change x_parallel during MULT -> no restart; result matches operands captured at start.
- Assert reset mid-MULT (iteration 6) -> product=0, fp=0, busy=0 asynchronously. After release with fx=fy=1 held, a new operation starts on the first edge.

Source files
------------

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier.
// Sits between the X/Y serial-to-parallel stages and the output serializer.
// A rising edge of (fx & fy) captures both operands. W add/shift iterations
// then build the 2W-bit product, which is presented with fp until ready drops.
module shift_add_multiplier #(
  parameter int W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W-1:0]     x_parallel,
  input  logic             fx,
  input  logic [W-1:0]     y_parallel,
  input  logic             fy,
  output logic [2*W-1:0]   product,
  output logic             busy,
  output logic             fp
);

  // The extra bit keeps the counter from wrapping at W for any width.
  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MULT = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t          state;
  state_t          state_next;

  logic            ready;
  logic            ready_q;
  logic            start;

  logic [W-1:0]    mcand;
  logic [W-1:0]    mplier;
  logic [W-1:0]    acc;
  logic [CW-1:0]   count;

  logic [W:0]      sum;
  logic [2*W-1:0]  shifted;
  logic            last_iter;

  // A new operation is launched only on a rise of the combined operand-valid level.
  assign ready     = fx & fy;
  assign start     = ready & ~ready_q;

  // Add the multiplicand when the current multiplier LSB is set, then shift
  // the whole {acc, mplier} pair right; the add carry becomes the new acc MSB.
  assign sum       = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : '0);
  assign shifted   = {sum, mplier[W-1:1]};
  assign last_iter = (count == CW'(W - 1));

  // State register with asynchronous reset back to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: launch on start, finish after W iterations, leave DONE when ready falls.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = MULT;
        end
      end
      MULT: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (!ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Status outputs decode directly from the registered state.
  always_comb begin
    busy = 1'b0;
    fp   = 1'b0;
    case (state)
      MULT:    busy = 1'b1;
      DONE:    fp   = 1'b1;
      default: begin
        busy = 1'b0;
        fp   = 1'b0;
      end
    endcase
  end

  // Datapath: operand capture, iteration, product update and the ready history bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q <= 1'b0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      ready_q <= ready;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= x_parallel;
            mplier <= y_parallel;
            acc    <= '0;
            count  <= '0;
          end
        end
        MULT: begin
          acc    <= shifted[2*W-1:W];
          mplier <= shifted[W-1:0];
          count  <= count + 1'b1;
          if (last_iter) begin
            product <= shifted;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier.
// A behavioural model tracks what the outputs must be from the operation rules
// (capture on a ready rise, W busy cycles, then a plain multiplication result),
// and a compare process checks busy/fp/product against it on every cycle.
module tb_shift_add_multiplier;

  localparam int W = 12;

  logic             clk;
  logic             reset;
  logic [W-1:0]     x_parallel;
  logic             fx;
  logic [W-1:0]     y_parallel;
  logic             fy;
  logic [2*W-1:0]   product;
  logic             busy;
  logic             fp;

  int               compared;
  int               mismatched;
  logic             check_en;

  // Reference model state: captured operands, busy cycles left, done flag, expected product.
  logic [W-1:0]     m_a;
  logic [W-1:0]     m_b;
  int               m_left;
  logic             m_done;
  logic             m_rq;
  logic [2*W-1:0]   m_prod;

  shift_add_multiplier #(.W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .x_parallel (x_parallel),
    .fx         (fx),
    .y_parallel (y_parallel),
    .fy         (fy),
    .product    (product),
    .busy       (busy),
    .fp         (fp)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: an operation occupies W cycles and then yields a*b.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_a    <= '0;
      m_b    <= '0;
      m_left <= 0;
      m_done <= 1'b0;
      m_rq   <= 1'b0;
      m_prod <= '0;
    end else begin
      m_rq <= fx & fy;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_prod <= (2*W)'(m_a) * (2*W)'(m_b);
          m_done <= 1'b1;
        end
      end else if (m_done) begin
        if (!(fx & fy)) begin
          m_done <= 1'b0;
        end
      end else if ((fx & fy) && !m_rq) begin
        m_a    <= x_parallel;
        m_b    <= y_parallel;
        m_left <= W;
      end
    end
  end

  // Every falling edge outside reset, compare the DUT outputs with the model.
  always @(negedge clk) begin
    if (!reset && check_en) begin
      compared++;
      if (busy !== (m_left > 0)) begin
        mismatched++;
        $display("[TB] FAIL model_busy t=%0t actual=%0b required=%0b", $time, busy, (m_left > 0));
      end
      compared++;
      if (fp !== m_done) begin
        mismatched++;
        $display("[TB] FAIL model_fp t=%0t actual=%0b required=%0b", $time, fp, m_done);
      end
      compared++;
      if (product !== m_prod) begin
        mismatched++;
        $display("[TB] FAIL model_product t=%0t actual=%0h required=%0h", $time, product, m_prod);
      end
    end
  end

  // Compare one observed value against a hand-computed literal.
  task automatic checkOutput(input string name, input logic [47:0] actual, input logic [47:0] required);
    compared++;
    if (actual !== required) begin
      mismatched++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  // Drive the operand words and valid levels just after a falling edge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic vx, input logic vy);
    @(negedge clk);
    #2;
    x_parallel = a;
    y_parallel = b;
    fx         = vx;
    fy         = vy;
  endtask

  // Launch one operation from IDLE and check latency, busy length and result.
  task automatic runOp(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] required);
    int edges;
    int busy_cycles;
    edges       = 0;
    busy_cycles = 0;
    applyStimulus(a, b, 1'b1, 1'b1);
    while (!fp && edges < 40) begin
      @(negedge clk);
      edges++;
      if (busy) busy_cycles++;
    end
    checkOutput({name, "_latency"}, 48'(edges), 48'd13);
    checkOutput({name, "_busy_cycles"}, 48'(busy_cycles), 48'd12);
    checkOutput({name, "_product"}, 48'(product), 48'(required));
  endtask

  // Drop both valids and confirm fp clears on the next edge.
  task automatic dropReady(input string name);
    applyStimulus(x_parallel, y_parallel, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput({name, "_fp_clear"}, 48'(fp), 48'd0);
  endtask

  // Bring the DUT back to IDLE with ready low, bounded in time.
  task automatic settleIdle();
    int n;
    n = 0;
    applyStimulus(x_parallel, y_parallel, 1'b0, 1'b0);
    while ((busy || fp) && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput("settle_idle", 48'(busy | fp), 48'd0);
  endtask

  // Main sequence: directed cases, hold/drop behaviour, mid-op glitches, random traffic, reset mid-op.
  initial begin
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;
    logic [2*W-1:0] held;
    compared   = 0;
    mismatched = 0;
    check_en   = 1'b0;
    reset      = 1'b1;
    fx         = 1'b0;
    fy         = 1'b0;
    x_parallel = '0;
    y_parallel = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_product", 48'(product), 48'd0);
    checkOutput("reset_busy", 48'(busy), 48'd0);
    checkOutput("reset_fp", 48'(fp), 48'd0);
    #2;
    reset    = 1'b0;
    check_en = 1'b1;

    runOp("op_3x5", 12'd3, 12'd5, 24'd15);
    dropReady("op_3x5");
    runOp("op_max", 12'd4095, 12'd4095, 24'hFFE001);
    dropReady("op_max");
    runOp("op_zero", 12'd0, 12'd2748, 24'd0);
    dropReady("op_zero");
    runOp("op_2048x2", 12'd2048, 12'd2, 24'd4096);

    // Ready held high in DONE keeps fp up without restarting.
    repeat (5) @(negedge clk);
    checkOutput("hold_fp", 48'(fp), 48'd1);
    checkOutput("hold_busy", 48'(busy), 48'd0);
    held = product;
    applyStimulus(x_parallel, y_parallel, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("drop_fy_fp", 48'(fp), 48'd0);
    checkOutput("drop_fy_product_held", 48'(product), 48'(held));
    applyStimulus(12'd7, 12'd9, 1'b1, 1'b0);
    runOp("op_7x9", 12'd7, 12'd9, 24'd63);
    dropReady("op_7x9");

    // Toggle fx and change x during MULT; the captured operands must win.
    applyStimulus(12'd100, 12'd200, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    applyStimulus(12'd555, 12'd200, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    applyStimulus(12'd777, 12'd321, 1'b1, 1'b1);
    repeat (12) @(negedge clk);
    checkOutput("glitch_fp", 48'(fp), 48'd1);
    checkOutput("glitch_product", 48'(product), 48'd20000);
    dropReady("glitch");

    // Random valid/operand traffic, including short ready pulses and mid-op toggles.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(W'($urandom), W'($urandom),
                    ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 8));
    end
    settleIdle();

    // Random complete operations against the hand-free multiply.
    for (int i = 0; i < 15; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      runOp("rand_op", ra, rb, (2*W)'(ra) * (2*W)'(rb));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      dropReady("rand_op");
    end

    // Reset in the middle of MULT, then relaunch with valids held high.
    runOp("pre_reset", 12'd1234, 12'd567, 24'd699678);
    dropReady("pre_reset");
    applyStimulus(12'd99, 12'd77, 1'b1, 1'b1);
    repeat (7) @(negedge clk);
    checkOutput("mid_busy_before_reset", 48'(busy), 48'd1);
    #2;
    check_en = 1'b0;
    reset    = 1'b1;
    #1;
    checkOutput("mid_reset_product", 48'(product), 48'd0);
    checkOutput("mid_reset_busy", 48'(busy), 48'd0);
    checkOutput("mid_reset_fp", 48'(fp), 48'd0);
    repeat (2) @(negedge clk);
    #2;
    reset    = 1'b0;
    check_en = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_start", 48'(busy), 48'd1);
    repeat (12) @(negedge clk);
    checkOutput("post_reset_fp", 48'(fp), 48'd1);
    checkOutput("post_reset_product", 48'(product), 48'd7623);
    dropReady("post_reset");

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
